// File: rtl/compensation_pingpong_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// compensation_pingpong_buffer : two-bank ping-pong store of per-column
// compensation weights, streamed one slot-beat (all lanes) per handshake.
// Revision 1.0
// ---------------------------------------------------------------------------
module compensation_pingpong_buffer #(
  parameter int unsigned SIZE     = 8,
  parameter int unsigned SLOTS    = 3,
  parameter int unsigned CW_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [CW_WIDTH-1:0]      wr_data,
  input  logic                     wr_col_end,
  input  logic                     wr_tile_end,
  output logic                     wr_ready,
  input  logic                     rd_start,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [SIZE*CW_WIDTH-1:0] rd_data,
  output logic                     rd_done,
  output logic [1:0]               bank_full,
  output logic                     err_overflow
);

  localparam int unsigned DEPTH = SIZE * SLOTS;
  localparam int unsigned IDX_W = $clog2(DEPTH + 1);
  localparam int unsigned K_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [IDX_W-1:0] C_DEPTH  = IDX_W'(DEPTH);
  localparam logic [K_W-1:0]   C_K_LAST = K_W'(SLOTS - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic                     wb_q, wb_d;
  logic                     rb_q, rb_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [1:0][DEPTH-1:0]    mask_q, mask_d;
  logic [1:0]               full_q, full_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     rd_done_q, rd_done_d;
  logic                     err_q, err_d;
  logic [SIZE*CW_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [SIZE*CW_WIDTH-1:0] beat_data;
  logic [CW_WIDTH-1:0]      mem_q [2][DEPTH];

  logic                     wr_ready_w;
  logic                     wr_acc;
  logic                     load_beat;
  logic [K_W-1:0]           beat_sel;
  logic [IDX_W-1:0]         col_next;
  int unsigned              col_base;

  // Next column base, saturated at DEPTH so an overfull index stays parked.
  always_comb begin
    col_base = (32'(idx_q) / SLOTS + 1) * SLOTS;
    if (col_base > DEPTH) col_base = DEPTH;
    col_next = col_base[IDX_W-1:0];
  end

  // Gather one beat: lane c reads entry c*SLOTS + beat_sel of the read bank.
  for (genvar c = 0; c < SIZE; c++) begin : g_lane
    localparam int unsigned BASE = c * SLOTS;
    logic [IDX_W-1:0] addr;
    assign addr = IDX_W'(BASE) + IDX_W'(beat_sel);
    assign beat_data[c*CW_WIDTH +: CW_WIDTH] =
      mask_q[rb_q][addr] ? mem_q[rb_q][addr] : '0;
  end

  always_comb begin
    wr_ready_w = !full_q[wb_q];
    wr_acc     = wr_valid && wr_ready_w && (idx_q < C_DEPTH);

    state_d    = state_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    idx_d      = idx_q;
    k_d        = k_q;
    mask_d     = mask_q;
    full_d     = full_q;
    rd_valid_d = rd_valid_q;
    rd_done_d  = 1'b0;
    err_d      = err_q;
    load_beat  = 1'b0;
    beat_sel   = k_q;

    // Write side
    if (wr_ready_w && wr_col_end) begin
      idx_d = col_next;
    end else if (wr_acc) begin
      idx_d = idx_q + IDX_W'(1);
    end
    if (wr_acc) mask_d[wb_q][idx_q] = 1'b1;
    if (wr_valid && wr_ready_w && (idx_q == C_DEPTH)) err_d = 1'b1;
    if (wr_tile_end && !wr_ready_w) err_d = 1'b1;
    if (wr_tile_end && wr_ready_w) begin
      full_d[wb_q] = 1'b1;
      wb_d         = ~wb_q;
      idx_d        = '0;
    end

    // Read side; rb never equals an open wb, so both sides can update freely.
    case (state_q)
      ST_IDLE: begin
        if (rd_start && full_q[rb_q]) begin
          state_d    = ST_STREAM;
          k_d        = '0;
          beat_sel   = '0;
          load_beat  = 1'b1;
          rd_valid_d = 1'b1;
        end
      end
      ST_STREAM: begin
        if (rd_ready) begin
          if (k_q == C_K_LAST) begin
            state_d      = ST_IDLE;
            rd_valid_d   = 1'b0;
            full_d[rb_q] = 1'b0;
            mask_d[rb_q] = '0;
            rb_d         = ~rb_q;
            k_d          = '0;
            rd_done_d    = 1'b1;
          end else begin
            k_d       = k_q + K_W'(1);
            beat_sel  = k_q + K_W'(1);
            load_beat = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_data_d = load_beat ? beat_data : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      idx_q      <= '0;
      k_q        <= '0;
      mask_q     <= '0;
      full_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      mask_q     <= mask_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
      rd_done_q  <= rd_done_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage is deliberately unreset; the valid masks hide stale contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wb_q][idx_q] <= wr_data;
  end

  assign wr_ready     = wr_ready_w;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_done      = rd_done_q;
  assign bank_full    = full_q;
  assign err_overflow = err_q;

endmodule
`default_nettype wire

// File: tb/tb_compensation_pingpong_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_compensation_pingpong_buffer : directed self-checking bench.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_compensation_pingpong_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [2:0]  wr_data;
  logic        wr_col_end;
  logic        wr_tile_end;
  logic        wr_ready;
  logic        rd_start;
  logic        rd_ready;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic        rd_done;
  logic [1:0]  bank_full;
  logic        err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  compensation_pingpong_buffer #(
    .SIZE(8), .SLOTS(3), .CW_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_col_end(wr_col_end),
    .wr_tile_end(wr_tile_end), .wr_ready(wr_ready),
    .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_done(rd_done), .bank_full(bank_full),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entry col*3+s receives s+base; col_end on each slot 2, tile_end on the last write.
  task automatic write_tile(input logic [2:0] base);
    for (int c = 0; c < 8; c++) begin
      for (int s = 0; s < 3; s++) begin
        wr_valid    = 1'b1;
        wr_data     = 3'(s) + base;
        wr_col_end  = (s == 2);
        wr_tile_end = (c == 7) && (s == 2);
        tick();
      end
    end
    wr_valid    = 1'b0;
    wr_col_end  = 1'b0;
    wr_tile_end = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 0; wr_data = 0; wr_col_end = 0; wr_tile_end = 0;
    rd_start = 0; rd_ready = 0;
    tick(); tick();
    rst = 1'b0;

    check("reset_rd_valid", 32'(rd_valid), 0);
    check("reset_rd_done", 32'(rd_done), 0);
    check("reset_rd_data", 32'(rd_data), 0);
    check("reset_bank_full", 32'(bank_full), 0);
    check("reset_wr_ready", 32'(wr_ready), 1);
    check("reset_err", 32'(err_overflow), 0);

    // Full tile
    write_tile(3'd1);
    check("full_commit_bank_full", 32'(bank_full), 32'h1);
    check("full_commit_wr_ready", 32'(wr_ready), 1);
    rd_start = 1; rd_ready = 1;
    tick();
    rd_start = 0;
    check("full_beat0_valid", 32'(rd_valid), 1);
    check("full_beat0", 32'(rd_data), 32'h249249);
    tick();
    check("full_beat1", 32'(rd_data), 32'h492492);
    tick();
    check("full_beat2", 32'(rd_data), 32'h6DB6DB);
    tick();
    check("full_done", 32'(rd_done), 1);
    check("full_end_valid", 32'(rd_valid), 0);
    check("full_end_bank_full", 32'(bank_full), 0);
    check("full_end_data_hold", 32'(rd_data), 32'h6DB6DB);
    tick();
    check("full_done_pulse", 32'(rd_done), 0);

    // Short column into bank 1
    wr_valid = 1; wr_data = 3'd5; wr_col_end = 1; wr_tile_end = 1;
    tick();
    wr_valid = 0; wr_col_end = 0; wr_tile_end = 0;
    check("short_bank_full", 32'(bank_full), 32'h2);
    rd_start = 1;
    tick();
    rd_start = 0;
    check("short_beat0", 32'(rd_data), 32'h000005);
    tick();
    check("short_beat1", 32'(rd_data), 32'h000000);
    tick();
    check("short_beat2", 32'(rd_data), 32'h000000);
    tick();
    check("short_done", 32'(rd_done), 1);
    check("short_bank_full_end", 32'(bank_full), 0);

    // Overflow
    for (int i = 0; i < 24; i++) begin
      wr_valid = 1; wr_data = 3'd7;
      tick();
    end
    check("ovf_before", 32'(err_overflow), 0);
    tick();
    wr_valid = 0;
    check("ovf_set", 32'(err_overflow), 1);
    tick(); tick();
    check("ovf_sticky", 32'(err_overflow), 1);
    check("ovf_no_commit", 32'(bank_full), 0);
    rst = 1;
    tick();
    rst = 0;
    check("ovf_rst_clear", 32'(err_overflow), 0);

    // Ping-pong: B written and committed while A is held under backpressure
    write_tile(3'd1);
    rd_start = 1; rd_ready = 1;
    tick();
    rd_start = 0; rd_ready = 0;
    check("pp_a_beat0", 32'(rd_data), 32'h249249);
    write_tile(3'd4);
    check("pp_both_full", 32'(bank_full), 32'h3);
    check("pp_wr_ready_low", 32'(wr_ready), 0);
    check("pp_a_hold", 32'(rd_data), 32'h249249);
    rd_ready = 1;
    tick();
    check("pp_a_beat1", 32'(rd_data), 32'h492492);
    check("pp_wr_ready_low1", 32'(wr_ready), 0);
    tick();
    check("pp_a_beat2", 32'(rd_data), 32'h6DB6DB);
    check("pp_wr_ready_low2", 32'(wr_ready), 0);
    tick();
    check("pp_a_done", 32'(rd_done), 1);
    check("pp_wr_ready_back", 32'(wr_ready), 1);
    check("pp_b_still_full", 32'(bank_full), 32'h2);
    rd_start = 1;
    tick();
    rd_start = 0;
    check("pp_b_beat0", 32'(rd_data), 32'h924924);
    tick();
    check("pp_b_beat1", 32'(rd_data), 32'hB6DB6D);
    tick();
    check("pp_b_beat2", 32'(rd_data), 32'hDB6DB6);
    tick();
    check("pp_b_done", 32'(bank_full), 0);

    // Commit attempt with no free bank
    write_tile(3'd1);
    write_tile(3'd4);
    check("tileend_full", 32'(bank_full), 32'h3);
    wr_tile_end = 1;
    tick();
    wr_tile_end = 0;
    check("tileend_err", 32'(err_overflow), 1);
    check("tileend_ignored", 32'(bank_full), 32'h3);

    // Backpressure at beat 1
    rd_start = 1; rd_ready = 1;
    tick();
    rd_start = 0;
    check("bp_beat0", 32'(rd_data), 32'h249249);
    tick();
    rd_ready = 0;
    check("bp_beat1", 32'(rd_data), 32'h492492);
    tick();
    check("bp_hold1", 32'(rd_data), 32'h492492);
    check("bp_hold_valid", 32'(rd_valid), 1);
    tick();
    check("bp_hold2", 32'(rd_data), 32'h492492);
    rd_ready = 1;
    tick();
    check("bp_beat2", 32'(rd_data), 32'h6DB6DB);
    tick();
    check("bp_done", 32'(rd_done), 1);

    // Reset during beat 1 of tile B
    rd_start = 1;
    tick();
    rd_start = 0;
    check("rst_b_beat0", 32'(rd_data), 32'h924924);
    tick();
    check("rst_b_beat1", 32'(rd_data), 32'hB6DB6D);
    rst = 1;
    tick();
    rst = 0;
    check("rst_mid_valid", 32'(rd_valid), 0);
    check("rst_mid_bank_full", 32'(bank_full), 0);
    check("rst_mid_wr_ready", 32'(wr_ready), 1);
    check("rst_mid_err", 32'(err_overflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
